// File: rtl/vertex_fetch_pkg.sv
// Shared types and constants for the vertex fetch unit: FSM state encoding,
// default BRAM latency and an index-width helper.
package vertex_fetch_pkg;

    localparam int DEFAULT_BRAM_LATENCY = 2;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_READY   = 3'd1;
    localparam logic [2:0] ST_FETCH   = 3'd2;
    localparam logic [2:0] ST_DRAIN   = 3'd3;
    localparam logic [2:0] ST_PRESENT = 3'd4;

    typedef enum logic [2:0] {
        FS_IDLE    = ST_IDLE,
        FS_READY   = ST_READY,
        FS_FETCH   = ST_FETCH,
        FS_DRAIN   = ST_DRAIN,
        FS_PRESENT = ST_PRESENT
    } fetch_state_t;

    // A single-dimension vector still needs a 1-bit index signal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vertex_fetch_read_tracker.sv
// read_tracker: LATENCY-deep shift register of {valid, dimension index} that
// follows each BRAM read and raises a capture strobe when its word returns.
module read_tracker
    import vertex_fetch_pkg::*;
#(
    parameter int LATENCY = DEFAULT_BRAM_LATENCY,
    parameter int IDX_W   = 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push_valid,
    input  logic [IDX_W-1:0] push_idx,
    output logic             cap_valid,
    output logic [IDX_W-1:0] cap_idx
);

    logic [LATENCY-1:0] valid_reg;
    logic [IDX_W-1:0]   idx_reg [LATENCY];

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < LATENCY; i++) begin
                valid_reg[i] <= 1'b0;
                idx_reg[i]   <= '0;
            end
        end else begin
            valid_reg[0] <= push_valid;
            idx_reg[0]   <= push_idx;
            for (int i = 1; i < LATENCY; i++) begin
                valid_reg[i] <= valid_reg[i-1];
                idx_reg[i]   <= idx_reg[i-1];
            end
        end
    end

    assign cap_valid = valid_reg[LATENCY-1];
    assign cap_idx   = idx_reg[LATENCY-1];

endmodule

// File: rtl/vertex_fetch.sv
// vertex_fetch: holds the query vector, fetches DIM coordinates per vertex ID
// from BRAM and presents both vectors to the distance unit until accepted.
// Optional feature macro: VERTEX_FETCH_REPEAT_SKIP_EN (repeat-ID cache skip).
module vertex_fetch
    import vertex_fetch_pkg::*;
#(
    parameter int DIM          = 2,
    parameter int ID_W         = 12,
    parameter int BRAM_LATENCY = DEFAULT_BRAM_LATENCY
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        query_valid_in,
    input  logic [DIM*32-1:0]           query_pos_in,
    output logic                        query_ready_out,
    input  logic                        id_valid_in,
    input  logic [ID_W-1:0]             id_in,
    output logic                        id_ready_out,
    output logic [ID_W+$clog2(DIM)-1:0] mem_addr_out,
    input  logic [31:0]                 mem_data_in,
    output logic [DIM*32-1:0]           vertex_pos_out,
    output logic [DIM*32-1:0]           query_pos_out,
    output logic [DIM-1:0]              data_valid_out,
    output logic [ID_W-1:0]             id_out,
    input  logic                        ready_in
);

    localparam int ADDR_W = ID_W + $clog2(DIM);
    localparam int IDX_W  = idx_width(DIM);

    fetch_state_t      state_reg;
    fetch_state_t      state_next;
    logic [ID_W-1:0]   id_reg;
    logic [IDX_W-1:0]  dim_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic              rd_valid_reg;
    logic [IDX_W-1:0]  rd_dim_reg;
    logic [DIM*32-1:0] query_reg;
    logic              data_valid_reg;
    logic [ID_W-1:0]   id_out_reg;
    logic              query_ready_reg;
    logic              id_ready_reg;

    logic              query_load;
    logic              id_accept;
    logic              last_capture;
    logic              cap_valid;
    logic [IDX_W-1:0]  cap_idx;
    logic [ADDR_W-1:0] base_addr;

`ifdef VERTEX_FETCH_REPEAT_SKIP_EN
    logic              cache_valid_reg;
    logic              skip_hit;

    assign skip_hit = cache_valid_reg && (id_in == id_out_reg);
`endif

    // A query load outranks an ID offered in the same cycle.
    assign query_load   = query_valid_in && ((state_reg == FS_IDLE) || (state_reg == FS_READY));
    assign id_accept    = id_ready_reg && id_valid_in && !query_valid_in;
    assign last_capture = cap_valid && (cap_idx == IDX_W'(DIM - 1));
    assign base_addr    = ADDR_W'(id_reg) * ADDR_W'(DIM);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FS_IDLE: begin
                if (query_valid_in) state_next = FS_READY;
            end
            FS_READY: begin
                if (query_valid_in) begin
                    state_next = FS_READY;
                end else if (id_valid_in) begin
`ifdef VERTEX_FETCH_REPEAT_SKIP_EN
                    state_next = skip_hit ? FS_PRESENT : FS_FETCH;
`else
                    state_next = FS_FETCH;
`endif
                end
            end
            FS_FETCH: begin
                if (dim_reg == IDX_W'(DIM - 1)) state_next = FS_DRAIN;
            end
            FS_DRAIN: begin
                if (last_capture) state_next = FS_PRESENT;
            end
            FS_PRESENT: begin
                if (data_valid_reg && ready_in) state_next = FS_READY;
            end
            default: state_next = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_reg       <= FS_IDLE;
            id_reg          <= '0;
            dim_reg         <= '0;
            mem_addr_reg    <= '0;
            rd_valid_reg    <= 1'b0;
            rd_dim_reg      <= '0;
            query_reg       <= '0;
            data_valid_reg  <= 1'b0;
            id_out_reg      <= '0;
            query_ready_reg <= 1'b0;
            id_ready_reg    <= 1'b0;
`ifdef VERTEX_FETCH_REPEAT_SKIP_EN
            cache_valid_reg <= 1'b0;
`endif
        end else begin
            state_reg       <= state_next;
            query_ready_reg <= (state_next == FS_IDLE) || (state_next == FS_READY);
            id_ready_reg    <= (state_next == FS_READY);
            rd_valid_reg    <= (state_reg == FS_FETCH);

            if (query_load) begin
                query_reg <= query_pos_in;
`ifdef VERTEX_FETCH_REPEAT_SKIP_EN
                cache_valid_reg <= 1'b0;
`endif
            end

            if (id_accept) begin
                id_reg  <= id_in;
                dim_reg <= '0;
            end

            // rd_valid/rd_dim describe the read currently on the address bus.
            if (state_reg == FS_FETCH) begin
                mem_addr_reg <= base_addr + ADDR_W'(dim_reg);
                rd_dim_reg   <= dim_reg;
                dim_reg      <= dim_reg + 1'b1;
            end

            if ((state_reg == FS_DRAIN) && last_capture) begin
                data_valid_reg <= 1'b1;
                id_out_reg     <= id_reg;
`ifdef VERTEX_FETCH_REPEAT_SKIP_EN
                cache_valid_reg <= 1'b1;
`endif
            end

            if (state_reg == FS_PRESENT) begin
`ifdef VERTEX_FETCH_REPEAT_SKIP_EN
                // A cache hit enters PRESENT with valid low; raise it one cycle later.
                if (!data_valid_reg) data_valid_reg <= 1'b1;
                else
`endif
                if (ready_in) data_valid_reg <= 1'b0;
            end
        end
    end

    read_tracker #(
        .LATENCY (BRAM_LATENCY),
        .IDX_W   (IDX_W)
    ) u_read_tracker (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .push_valid (rd_valid_reg),
        .push_idx   (rd_dim_reg),
        .cap_valid  (cap_valid),
        .cap_idx    (cap_idx)
    );

    genvar gi;
    generate
        for (gi = 0; gi < DIM; gi++) begin : g_lane
            logic [31:0] pos_reg;

            always_ff @(posedge clk_in) begin
                if (!rst_in) begin
                    pos_reg <= '0;
                end else if (cap_valid && (cap_idx == IDX_W'(gi))) begin
                    pos_reg <= mem_data_in;
                end
            end

            assign vertex_pos_out[gi*32 +: 32] = pos_reg;
            assign data_valid_out[gi]          = data_valid_reg;
        end
    endgenerate

    assign query_ready_out = query_ready_reg;
    assign id_ready_out    = id_ready_reg;
    assign mem_addr_out    = mem_addr_reg;
    assign query_pos_out   = query_reg;
    assign id_out          = id_out_reg;

endmodule

// File: tb/tb_vertex_fetch.sv
// Directed testbench for vertex_fetch (default build, DIM=2, latency 2) with a
// two-stage BRAM model returning mem[a] = a*16.
module tb_vertex_fetch;

    localparam int DIM    = 2;
    localparam int ID_W   = 12;
    localparam int ADDR_W = ID_W + 1;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              query_valid_in;
    logic [DIM*32-1:0] query_pos_in;
    logic              query_ready_out;
    logic              id_valid_in;
    logic [ID_W-1:0]   id_in;
    logic              id_ready_out;
    logic [ADDR_W-1:0] mem_addr_out;
    logic [31:0]       mem_data_in;
    logic [DIM*32-1:0] vertex_pos_out;
    logic [DIM*32-1:0] query_pos_out;
    logic [DIM-1:0]    data_valid_out;
    logic [ID_W-1:0]   id_out;
    logic              ready_in;

    int errors = 0;
    int checks = 0;

    logic [31:0] bram_pipe0;
    logic [31:0] bram_pipe1;

    vertex_fetch #(.DIM(DIM), .ID_W(ID_W), .BRAM_LATENCY(2)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .query_valid_in  (query_valid_in),
        .query_pos_in    (query_pos_in),
        .query_ready_out (query_ready_out),
        .id_valid_in     (id_valid_in),
        .id_in           (id_in),
        .id_ready_out    (id_ready_out),
        .mem_addr_out    (mem_addr_out),
        .mem_data_in     (mem_data_in),
        .vertex_pos_out  (vertex_pos_out),
        .query_pos_out   (query_pos_out),
        .data_valid_out  (data_valid_out),
        .id_out          (id_out),
        .ready_in        (ready_in)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        bram_pipe0 <= 32'(mem_addr_out) * 32'd16;
        bram_pipe1 <= bram_pipe0;
    end
    assign mem_data_in = bram_pipe1;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        rst_in = 1'b0; query_valid_in = 1'b0; query_pos_in = '0;
        id_valid_in = 1'b0; id_in = '0; ready_in = 1'b0;
        tick(); tick();
        checks++; if (query_ready_out !== 1'b0) begin errors++; $display("FAIL reset_query_ready: got %b expected 0", query_ready_out); end
        checks++; if (id_ready_out !== 1'b0) begin errors++; $display("FAIL reset_id_ready: got %b expected 0", id_ready_out); end
        checks++; if (mem_addr_out !== '0) begin errors++; $display("FAIL reset_mem_addr: got %0d expected 0", mem_addr_out); end
        checks++; if (vertex_pos_out !== '0) begin errors++; $display("FAIL reset_vertex_pos: got %h expected 0", vertex_pos_out); end
        checks++; if (query_pos_out !== '0) begin errors++; $display("FAIL reset_query_pos: got %h expected 0", query_pos_out); end
        checks++; if (data_valid_out !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b expected 00", data_valid_out); end
        checks++; if (id_out !== '0) begin errors++; $display("FAIL reset_id_out: got %0d expected 0", id_out); end
        rst_in = 1'b1;
        tick();
        checks++; if (query_ready_out !== 1'b1) begin errors++; $display("FAIL post_reset_query_ready: got %b expected 1", query_ready_out); end
        checks++; if (id_ready_out !== 1'b0) begin errors++; $display("FAIL post_reset_id_ready: got %b expected 0", id_ready_out); end
        $display("reset: released, state idle");
    endtask

    task automatic test_id_before_query();
        id_valid_in = 1'b1; id_in = 12'd4;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (id_ready_out !== 1'b0) begin errors++; $display("FAIL noquery_id_ready: got %b expected 0", id_ready_out); end
            checks++; if (mem_addr_out !== '0) begin errors++; $display("FAIL noquery_mem_addr: got %0d expected 0", mem_addr_out); end
            checks++; if (data_valid_out !== 2'b00 || vertex_pos_out !== '0 || id_out !== '0) begin
                errors++; $display("FAIL noquery_outputs: got valid=%b vertex=%h id=%0d expected all 0", data_valid_out, vertex_pos_out, id_out);
            end
        end
        id_valid_in = 1'b0;
        $display("id=4 offered without query: refused");
    endtask

    task automatic test_fetch_and_hold();
        query_valid_in = 1'b1; query_pos_in = {32'd7, 32'd5};
        tick();
        query_valid_in = 1'b0;
        checks++; if (id_ready_out !== 1'b1) begin errors++; $display("FAIL load_id_ready: got %b expected 1", id_ready_out); end
        id_valid_in = 1'b1; id_in = 12'd3;
        tick();                                   // edge T
        id_valid_in = 1'b0;
        checks++; if (id_ready_out !== 1'b0) begin errors++; $display("FAIL fetch_id_ready: got %b expected 0", id_ready_out); end
        tick();                                   // T+1
        checks++; if (mem_addr_out !== 13'd6) begin errors++; $display("FAIL fetch_addr0: got %0d expected 6", mem_addr_out); end
        tick();                                   // T+2
        checks++; if (mem_addr_out !== 13'd7) begin errors++; $display("FAIL fetch_addr1: got %0d expected 7", mem_addr_out); end
        tick(); tick();                           // T+4
        checks++; if (data_valid_out !== 2'b00) begin errors++; $display("FAIL fetch_early_valid: got %b expected 00", data_valid_out); end
        tick();                                   // T+5
        checks++; if (data_valid_out !== 2'b11) begin errors++; $display("FAIL fetch_valid: got %b expected 11", data_valid_out); end
        checks++; if (vertex_pos_out !== {32'd112, 32'd96}) begin errors++; $display("FAIL fetch_vertex: got %h expected %h", vertex_pos_out, {32'd112, 32'd96}); end
        checks++; if (query_pos_out !== {32'd7, 32'd5}) begin errors++; $display("FAIL fetch_query: got %h expected %h", query_pos_out, {32'd7, 32'd5}); end
        checks++; if (id_out !== 12'd3) begin errors++; $display("FAIL fetch_id_out: got %0d expected 3", id_out); end
        $display("fetch id=3: vertex=(%0d,%0d) query=(%0d,%0d)", vertex_pos_out[31:0], vertex_pos_out[63:32], query_pos_out[31:0], query_pos_out[63:32]);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (data_valid_out !== 2'b11 || vertex_pos_out !== {32'd112, 32'd96} || id_out !== 12'd3) begin
                errors++; $display("FAIL hold_outputs: got valid=%b vertex=%h id=%0d expected 11/%h/3", data_valid_out, vertex_pos_out, id_out, {32'd112, 32'd96});
            end
            checks++; if (id_ready_out !== 1'b0) begin errors++; $display("FAIL hold_id_ready: got %b expected 0", id_ready_out); end
        end
        ready_in = 1'b1;
        tick();                                   // edge P
        ready_in = 1'b0;
        checks++; if (data_valid_out !== 2'b00) begin errors++; $display("FAIL handoff_valid: got %b expected 00", data_valid_out); end
        checks++; if (id_ready_out !== 1'b1) begin errors++; $display("FAIL handoff_id_ready: got %b expected 1", id_ready_out); end
        $display("handoff id=3 after 4 stalled cycles");
    endtask

    task automatic test_query_reload();
        query_valid_in = 1'b1; query_pos_in = {32'd1, 32'd1};
        id_valid_in = 1'b1; id_in = 12'd0;
        tick();
        query_valid_in = 1'b0; id_valid_in = 1'b0;
        checks++; if (query_pos_out !== {32'd1, 32'd1}) begin errors++; $display("FAIL reload_query: got %h expected %h", query_pos_out, {32'd1, 32'd1}); end
        checks++; if (id_ready_out !== 1'b1 || mem_addr_out !== 13'd7) begin
            errors++; $display("FAIL reload_id_refused: got id_ready=%b addr=%0d expected 1/7", id_ready_out, mem_addr_out);
        end
        id_valid_in = 1'b1; id_in = 12'd0;
        tick();                                   // edge T
        id_valid_in = 1'b0;
        query_valid_in = 1'b1; query_pos_in = {32'd9, 32'd9};
        tick();                                   // T+1
        query_valid_in = 1'b0;
        checks++; if (mem_addr_out !== 13'd0) begin errors++; $display("FAIL reload_addr0: got %0d expected 0", mem_addr_out); end
        checks++; if (query_ready_out !== 1'b0) begin errors++; $display("FAIL reload_query_ready: got %b expected 0", query_ready_out); end
        tick();                                   // T+2
        checks++; if (mem_addr_out !== 13'd1) begin errors++; $display("FAIL reload_addr1: got %0d expected 1", mem_addr_out); end
        tick(); tick(); tick();                   // T+5
        checks++; if (data_valid_out !== 2'b11 || vertex_pos_out !== {32'd16, 32'd0}) begin
            errors++; $display("FAIL reload_vertex: got valid=%b vertex=%h expected 11/%h", data_valid_out, vertex_pos_out, {32'd16, 32'd0});
        end
        checks++; if (query_pos_out !== {32'd1, 32'd1}) begin errors++; $display("FAIL reload_query_kept: got %h expected %h", query_pos_out, {32'd1, 32'd1}); end
        checks++; if (id_out !== 12'd0) begin errors++; $display("FAIL reload_id_out: got %0d expected 0", id_out); end
        $display("fetch id=0 with query (1,1): vertex=(%0d,%0d)", vertex_pos_out[31:0], vertex_pos_out[63:32]);
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat;
        int wait_cycles;
        ready_in = 1'b1;
        for (int rep = 0; rep < 2; rep++) begin
            wait_cycles = 0;
            while (id_ready_out !== 1'b1 && wait_cycles < 10) begin
                tick(); wait_cycles++;
            end
            checks++; if (id_ready_out !== 1'b1) begin errors++; $display("FAIL b2b_wait_ready: got %b expected 1", id_ready_out); end
            id_valid_in = 1'b1; id_in = 12'd3;
            tick();                               // edge T
            id_valid_in = 1'b0;
            tick();                               // T+1
            lat = 1;
            checks++; if (mem_addr_out !== 13'd6) begin errors++; $display("FAIL b2b_addr: got %0d expected 6", mem_addr_out); end
            while (data_valid_out !== 2'b11 && lat < 20) begin
                tick(); lat++;
            end
            checks++; if (lat !== 5) begin errors++; $display("FAIL b2b_latency: got %0d expected 5", lat); end
            checks++; if (vertex_pos_out !== {32'd112, 32'd96}) begin errors++; $display("FAIL b2b_vertex: got %h expected %h", vertex_pos_out, {32'd112, 32'd96}); end
            $display("repeat id=3 request %0d: latency=%0d", rep, lat);
        end
        tick();
        ready_in = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        query_valid_in = 1'b1; query_pos_in = {32'd3, 32'd2};
        tick();
        query_valid_in = 1'b0;
        id_valid_in = 1'b1; id_in = 12'd2;
        tick();                                   // edge T
        id_valid_in = 1'b0;
        tick();                                   // T+1
        checks++; if (mem_addr_out !== 13'd4) begin errors++; $display("FAIL midrst_addr: got %0d expected 4", mem_addr_out); end
        rst_in = 1'b0;
        tick();                                   // T+2
        checks++; if (query_ready_out !== 1'b0 || id_ready_out !== 1'b0 || mem_addr_out !== '0) begin
            errors++; $display("FAIL midrst_ctrl: got qr=%b ir=%b addr=%0d expected 0/0/0", query_ready_out, id_ready_out, mem_addr_out);
        end
        checks++; if (vertex_pos_out !== '0 || query_pos_out !== '0 || data_valid_out !== 2'b00 || id_out !== '0) begin
            errors++; $display("FAIL midrst_data: got vertex=%h query=%h valid=%b id=%0d expected all 0", vertex_pos_out, query_pos_out, data_valid_out, id_out);
        end
        rst_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (vertex_pos_out !== '0 || data_valid_out !== 2'b00) begin
                errors++; $display("FAIL midrst_late_data: got vertex=%h valid=%b expected 0/00", vertex_pos_out, data_valid_out);
            end
        end
        checks++; if (query_ready_out !== 1'b1 || id_ready_out !== 1'b0 || query_pos_out !== '0) begin
            errors++; $display("FAIL midrst_idle: got qr=%b ir=%b query=%h expected 1/0/0", query_ready_out, id_ready_out, query_pos_out);
        end
        $display("reset during fetch of id=2: returned to idle");
    endtask

    initial begin
        test_reset();
        test_id_before_query();
        test_fetch_and_hold();
        test_query_reload();
        test_back_to_back();
        test_reset_mid_fetch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
